// File: rtl/wb_pkg.sv
// Shared writeback-select encodings and the write-port grant type.
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;
    localparam logic [1:0] WB_SEL_RSVD = 2'b11;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_ASYNC
    } grant_e;

endpackage

// File: rtl/wb_resp_fifo.sv
// Small circular queue for out-of-order async results; power-of-2 depth, no fall-through.
module wb_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 37
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_data  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order pipe writeback vs queued async results.
// Optional macro WB_FAIRNESS_EN bounds how long an async head can be starved by the pipe.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_AW     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pipe_valid,
    input  logic [1:0]        i_pipe_sel,
    input  logic [REG_AW-1:0] i_pipe_rd,
    input  logic [WIDTH-1:0]  i_alu_result,
    input  logic [WIDTH-1:0]  i_memory_data,
    input  logic [WIDTH-1:0]  i_pc,
    output logic              o_pipe_stall,
    input  logic              i_async_valid,
    input  logic [REG_AW-1:0] i_async_rd,
    input  logic [WIDTH-1:0]  i_async_data,
    output logic              o_async_ready,
    output logic              o_rf_we,
    output logic [REG_AW-1:0] o_rf_rd,
    output logic [WIDTH-1:0]  o_rf_wdata,
    output logic              o_async_pending
);

    localparam int PLW = REG_AW + WIDTH;

    logic [PLW-1:0]    head;
    logic [REG_AW-1:0] head_rd;
    logic [WIDTH-1:0]  head_data;
    logic              fifo_full, fifo_empty, push, pop;
    logic [WIDTH-1:0]  pipe_wdata;
    logic              pipe_we, force_async;
    grant_e            grant;

    logic              we_q, we_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;

    assign push = i_async_valid && !fifo_full;
    assign pop  = (grant == GNT_ASYNC);

    wb_resp_fifo #(.DEPTH(FIFO_DEPTH), .DW(PLW)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  ({i_async_rd, i_async_data}),
        .i_pop   (pop),
        .o_data  (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign head_rd         = head[PLW-1:WIDTH];
    assign head_data       = head[WIDTH-1:0];
    assign o_async_ready   = !fifo_full;
    assign o_async_pending = !fifo_empty;

    always_comb begin
        pipe_wdata = '0;
        case (i_pipe_sel)
            WB_SEL_ALU:  pipe_wdata = i_alu_result;
            WB_SEL_LOAD: pipe_wdata = i_memory_data;
            WB_SEL_LINK: pipe_wdata = i_pc + WIDTH'(4);
            default:     pipe_wdata = '0;
        endcase
    end
    assign pipe_we = (i_pipe_rd != '0) && (i_pipe_sel != WB_SEL_RSVD);

`ifdef WB_FAIRNESS_EN
    logic [7:0] wait_q, wait_d;

    assign force_async  = i_pipe_valid && !fifo_empty && (wait_q == 8'(MAX_WAIT));
    assign o_pipe_stall = i_pipe_valid && (grant != GNT_PIPE);

    always_comb begin
        wait_d = wait_q;
        if (fifo_empty || pop)            wait_d = '0;
        else if (wait_q != 8'(MAX_WAIT))  wait_d = wait_q + 8'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) wait_q <= '0;
        else          wait_q <= wait_d;
    end
`else
    assign force_async  = 1'b0;
    assign o_pipe_stall = 1'b0;
`endif

    always_comb begin
        grant = GNT_NONE;
        if (force_async)       grant = GNT_ASYNC;
        else if (i_pipe_valid) grant = GNT_PIPE;
        else if (!fifo_empty)  grant = GNT_ASYNC;
    end

    // x0 and reserved-select requests are consumed but never raise the write enable.
    always_comb begin
        we_d    = 1'b0;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        case (grant)
            GNT_PIPE: begin
                we_d    = pipe_we;
                rd_d    = i_pipe_rd;
                wdata_d = pipe_wdata;
            end
            GNT_ASYNC: begin
                we_d    = (head_rd != '0);
                rd_d    = head_rd;
                wdata_d = head_data;
            end
            default: we_d = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q    <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_rf_we    = we_q;
    assign o_rf_rd    = rd_q;
    assign o_rf_wdata = wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized + directed bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    localparam int WIDTH = 32, REG_AW = 5, DEPTH = 2, MAX_WAIT = 4;
`ifdef WB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct packed { logic [REG_AW-1:0] rd; logic [WIDTH-1:0] data; } ent_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic pipe_valid = 0, async_valid = 0;
    logic [1:0] pipe_sel = 0;
    logic [REG_AW-1:0] pipe_rd = 0, async_rd = 0;
    logic [WIDTH-1:0] alu = 0, mem = 0, pc = 0, async_data = 0;
    logic pipe_stall, async_ready, rf_we, async_pending;
    logic [REG_AW-1:0] rf_rd;
    logic [WIDTH-1:0] rf_wdata;

    int checks = 0, errors = 0;

    // reference model state
    ent_t mq[$];
    int   m_wait, m_gnt;          // m_gnt: 0 none, 1 pipe, 2 async
    logic exp_we, exp_stall, exp_ready, exp_pending;
    logic [REG_AW-1:0] exp_rd;
    logic [WIDTH-1:0] exp_wdata;

    always #5 clk = ~clk;

    wb_port_arbiter #(.WIDTH(WIDTH), .REG_AW(REG_AW), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_pipe_valid(pipe_valid), .i_pipe_sel(pipe_sel), .i_pipe_rd(pipe_rd),
        .i_alu_result(alu), .i_memory_data(mem), .i_pc(pc), .o_pipe_stall(pipe_stall),
        .i_async_valid(async_valid), .i_async_rd(async_rd), .i_async_data(async_data),
        .o_async_ready(async_ready),
        .o_rf_we(rf_we), .o_rf_rd(rf_rd), .o_rf_wdata(rf_wdata), .o_async_pending(async_pending)
    );

    task automatic model_clear();
        mq.delete(); m_wait = 0; exp_we = 0; exp_rd = '0; exp_wdata = '0;
    endtask

    task automatic model_pre();
        if (FAIR && pipe_valid && mq.size() > 0 && m_wait == MAX_WAIT) m_gnt = 2;
        else if (pipe_valid)                                          m_gnt = 1;
        else if (mq.size() > 0)                                       m_gnt = 2;
        else                                                          m_gnt = 0;
        exp_stall   = pipe_valid && (m_gnt != 1);
        exp_ready   = (mq.size() < DEPTH);
        exp_pending = (mq.size() != 0);
    endtask

    // one clock: evaluate the model on the current inputs, advance, land on the next negedge
    task automatic tick();
        int sz;
        ent_t e;
        model_pre();
        @(posedge clk);
        if (rst_n) begin
            sz = mq.size();
            if (m_gnt == 1) begin
                exp_we = (pipe_rd != 0) && (pipe_sel != 2'b11);
                exp_rd = pipe_rd;
                case (pipe_sel)
                    2'b00:   exp_wdata = alu;
                    2'b01:   exp_wdata = mem;
                    2'b10:   exp_wdata = pc + 32'd4;
                    default: exp_wdata = '0;
                endcase
            end else if (m_gnt == 2) begin
                e = mq.pop_front();
                exp_we = (e.rd != 0); exp_rd = e.rd; exp_wdata = e.data;
            end else begin
                exp_we = 1'b0;
            end
            if (sz == 0 || m_gnt == 2) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
            if (async_valid && sz < DEPTH) mq.push_back({async_rd, async_data});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        pipe_valid = 0; async_valid = 0;
    endtask

    task automatic set_pipe(input logic [1:0] s, input logic [4:0] r, input logic [31:0] v);
        pipe_valid = 1; pipe_sel = s; pipe_rd = r; alu = v; mem = v; pc = v;
    endtask

    task automatic test_reset();
        rst_n = 0; model_clear();
        for (int i = 0; i < 5; i++) begin
            pipe_valid = 1'($urandom); pipe_sel = 2'($urandom); pipe_rd = 5'($urandom);
            alu = $urandom; mem = $urandom; pc = $urandom;
            async_valid = 1'($urandom); async_rd = 5'($urandom); async_data = $urandom;
            #1;
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", rf_we); end
            checks++; if (rf_rd !== '0) begin errors++; $display("FAIL reset_rd got %h exp 0", rf_rd); end
            checks++; if (rf_wdata !== '0) begin errors++; $display("FAIL reset_wdata got %h exp 0", rf_wdata); end
            checks++; if (async_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", async_ready); end
            checks++; if (async_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", async_pending); end
            @(negedge clk);
        end
        idle(); rst_n = 1;
        tick();
    endtask

    task automatic test_pipe_write();
        pipe_valid = 1; pipe_sel = 2'b10; pipe_rd = 5; pc = 32'h100; tick();
        checks++; if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd5, 32'h104})
            begin errors++; $display("FAIL link_write got we=%b rd=%0d d=%h exp we=1 rd=5 d=104", rf_we, rf_rd, rf_wdata); end
        pipe_sel = 2'b11; tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rsvd_sel_we got %b exp 0", rf_we); end
        set_pipe(2'b00, 0, 32'h55); tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got %b exp 0", rf_we); end
        set_pipe(2'b01, 9, 32'hCAFE); alu = 32'h1; tick();
        checks++; if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd9, 32'hCAFE})
            begin errors++; $display("FAIL load_write got we=%b rd=%0d d=%h exp we=1 rd=9 d=cafe", rf_we, rf_rd, rf_wdata); end
        set_pipe(2'b10, 1, 32'hFFFF_FFFC); tick();
        checks++; if ({rf_we, rf_wdata} !== {1'b1, 32'h0})
            begin errors++; $display("FAIL link_wrap got we=%b d=%h exp we=1 d=0", rf_we, rf_wdata); end
        idle(); tick();
        checks++; if ({rf_we, rf_rd, rf_wdata} !== {1'b0, 5'd1, 32'h0})
            begin errors++; $display("FAIL idle_hold got we=%b rd=%0d d=%h exp we=0 rd=1 d=0", rf_we, rf_rd, rf_wdata); end
    endtask

    task automatic test_same_cycle();
        set_pipe(2'b00, 3, 32'h11);
        async_valid = 1; async_rd = 7; async_data = 32'hAA; tick();
        checks++; if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd3, 32'h11})
            begin errors++; $display("FAIL same_pipe got we=%b rd=%0d d=%h exp we=1 rd=3 d=11", rf_we, rf_rd, rf_wdata); end
        idle(); #1;
        checks++; if (async_pending !== 1'b1) begin errors++; $display("FAIL same_pending got %b exp 1", async_pending); end
        tick();
        checks++; if ({rf_we, rf_rd, rf_wdata, async_pending} !== {1'b1, 5'd7, 32'hAA, 1'b0})
            begin errors++; $display("FAIL same_async got we=%b rd=%0d d=%h pend=%b exp 1 7 aa 0", rf_we, rf_rd, rf_wdata, async_pending); end
    endtask

    task automatic test_fifo_full();
        set_pipe(2'b00, 2, 32'h1234);
        async_valid = 1; async_rd = 10; async_data = 32'hA1; #1;
        checks++; if (async_ready !== 1'b1) begin errors++; $display("FAIL full_ready0 got %b exp 1", async_ready); end
        tick();
        async_rd = 11; async_data = 32'hA2; tick();
        checks++; if (async_ready !== 1'b0) begin errors++; $display("FAIL full_ready2 got %b exp 0", async_ready); end
        async_rd = 12; async_data = 32'hA3; tick();
        checks++; if ({async_ready, async_pending} !== 2'b01)
            begin errors++; $display("FAIL full_hold got ready=%b pend=%b exp 0 1", async_ready, async_pending); end
        pipe_valid = 0; tick();
        checks++; if ({rf_we, rf_rd, rf_wdata, async_ready} !== {1'b1, 5'd10, 32'hA1, 1'b1})
            begin errors++; $display("FAIL full_pop1 got we=%b rd=%0d d=%h ready=%b exp 1 10 a1 1", rf_we, rf_rd, rf_wdata, async_ready); end
        tick();
        async_valid = 0;
        checks++; if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd11, 32'hA2})
            begin errors++; $display("FAIL full_pop2 got we=%b rd=%0d d=%h exp 1 11 a2", rf_we, rf_rd, rf_wdata); end
        tick();
        checks++; if ({rf_we, rf_rd, rf_wdata, async_pending} !== {1'b1, 5'd12, 32'hA3, 1'b0})
            begin errors++; $display("FAIL full_pop3 got we=%b rd=%0d d=%h pend=%b exp 1 12 a3 0", rf_we, rf_rd, rf_wdata, async_pending); end
    endtask

    task automatic test_fairness();
        int stalls = 0, awrites = 0;
        set_pipe(2'b00, 4, 32'h0000_0100);
        async_valid = 1; async_rd = 20; async_data = 32'hDEAD_BEEF; tick();
        async_valid = 0;
        for (int i = 0; i < 12; i++) begin
            if (!exp_stall) set_pipe(2'b00, 5'($urandom_range(1, 19)), $urandom & 32'h0FFF_FFFF);
            #1; model_pre();
            checks++; if (pipe_stall !== exp_stall) begin errors++; $display("FAIL fair_stall got %b exp %b", pipe_stall, exp_stall); end
            if (pipe_stall) stalls++;
            tick();
            checks++; if (rf_we !== exp_we) begin errors++; $display("FAIL fair_we got %b exp %b", rf_we, exp_we); end
            if (rf_we && rf_rd == 20 && rf_wdata == 32'hDEAD_BEEF) awrites++;
        end
        checks++; if (stalls != (FAIR ? 1 : 0)) begin errors++; $display("FAIL fair_stall_count got %0d exp %0d", stalls, FAIR ? 1 : 0); end
        checks++; if (awrites != (FAIR ? 1 : 0)) begin errors++; $display("FAIL fair_async_busy got %0d exp %0d", awrites, FAIR ? 1 : 0); end
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            if (rf_we && rf_rd == 20 && rf_wdata == 32'hDEAD_BEEF) awrites++;
        end
        checks++; if (awrites != 1) begin errors++; $display("FAIL fair_async_total got %0d exp 1", awrites); end
    endtask

    task automatic test_reset_flush();
        int seen = 0;
        set_pipe(2'b00, 6, 32'h77);
        async_valid = 1; async_rd = 25; async_data = 32'h2525; tick();
        async_rd = 26; async_data = 32'h2626; tick();
        idle(); #1;
        checks++; if (async_pending !== 1'b1) begin errors++; $display("FAIL flush_pre got %b exp 1", async_pending); end
        rst_n = 0; model_clear(); #1;
        checks++; if ({async_pending, async_ready, rf_we} !== 3'b010)
            begin errors++; $display("FAIL flush_rst got pend=%b ready=%b we=%b exp 0 1 0", async_pending, async_ready, rf_we); end
        tick(); rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rf_we || async_pending) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_after got %0d activity cycles exp 0", seen); end
    endtask

    task automatic test_random();
        logic hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                pipe_valid = ($urandom_range(0, 9) < 6);
                pipe_sel = 2'($urandom); pipe_rd = 5'($urandom);
                alu = $urandom; mem = $urandom;
                pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            end
            async_valid = 1'($urandom); async_rd = 5'($urandom); async_data = $urandom;
            #1; model_pre();
            checks++; if ({pipe_stall, async_ready, async_pending} !== {exp_stall, exp_ready, exp_pending})
                begin errors++; $display("FAIL rnd_comb got st/rdy/pend=%b%b%b exp %b%b%b", pipe_stall, async_ready, async_pending, exp_stall, exp_ready, exp_pending); end
            hold = exp_stall;
            tick();
            checks++; if (rf_we !== exp_we) begin errors++; $display("FAIL rnd_we got %b exp %b", rf_we, exp_we); end
            if (exp_we) begin
                checks++; if ({rf_rd, rf_wdata} !== {exp_rd, exp_wdata})
                    begin errors++; $display("FAIL rnd_write got rd=%0d d=%h exp rd=%0d d=%h", rf_rd, rf_wdata, exp_rd, exp_wdata); end
            end
        end
        idle();
        for (int i = 0; i < 4; i++) tick();
        checks++; if (async_pending !== 1'b0) begin errors++; $display("FAIL rnd_drain got %b exp 0", async_pending); end
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        test_reset();
        test_pipe_write();
        test_same_cycle();
        test_fifo_full();
        test_fairness();
        test_reset_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
